// File: rtl/adam_syscfg_seq_pkg.sv
// adam_syscfg_seq_pkg
//   Shared types and helpers for the syscfg power-up/pause sequencer.
//   SEQ_STATE_T : sequencer FSM states
//   max_u       : larger of two unsigned ints, used to size the shared counter
package adam_syscfg_seq_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        REL_RST = 3'd1,
        SETTLE  = 3'd2,
        RESUME  = 3'd3,
        RUN     = 3'd4,
        PAUSE   = 3'd5,
        PAUSED  = 3'd6
    } SEQ_STATE_T;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adam_syscfg_seq_tmr.sv
// adam_syscfg_seq_tmr
//   Loadable down-counter shared by the settle wait and the ack-wait timeout.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load value_i this cycle (has priority over counting)
//   value_i    : count to load, >= 1
//   expired_o  : high during the last cycle of a loaded count
module adam_syscfg_seq_tmr
    import adam_syscfg_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A load of N gives exactly N cycles with the last one flagged.
    assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/adam_syscfg_seq.sv
// adam_syscfg_seq
//   Ordered power-up/pause sequencer for syscfg targets. Boot releases reset then
//   pause of each target in index order; upstream pause pauses targets in reverse
//   order; resume releases pauses in forward order without re-applying reset.
//   clk, rst_n     : clock, async active-low reset
//   boot_en        : starts the boot sequence (sampled only in OFF)
//   pause_req/ack  : upstream pause slave handshake (ack=1: all paused / not booted)
//   tgt_rst        : per-target reset, 1 = held
//   tgt_pause_req  : per-target pause request
//   tgt_pause_ack  : per-target pause ack
//   busy           : sequence in progress
//   err            : sticky ack-wait timeout flag
//   Optional: ADAM_SYSCFG_SEQ_TIMEOUT_EN bounds every ack wait to TIMEOUT_CYCLES;
//   without it, waits are unbounded and err is tied to 0.
module adam_syscfg_seq
    import adam_syscfg_seq_pkg::*;
#(
    parameter int unsigned NO_TGTS        = 4,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               boot_en,
    input  logic               pause_req,
    output logic               pause_ack,
    output logic [NO_TGTS-1:0] tgt_rst,
    output logic [NO_TGTS-1:0] tgt_pause_req,
    input  logic [NO_TGTS-1:0] tgt_pause_ack,
    output logic               busy,
    output logic               err
);

    localparam int unsigned IDX_W = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1;
    localparam int unsigned CNT_W = $clog2(max_u(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NO_TGTS - 1);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);

    SEQ_STATE_T         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, nxt, prv;
    logic [NO_TGTS-1:0] rst_q, rst_d, preq_q, preq_d;
    logic               pack_q, pack_d, busy_q, busy_d;
    logic               tmr_load, tmr_exp, to_exp;
    logic [CNT_W-1:0]   tmr_val;

    assign nxt = idx_q + 1'b1;
    assign prv = idx_q - 1'b1;

`ifdef ADAM_SYSCFG_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    logic err_q;
    // The timer only runs a timeout in the ack-wait states, so expiry there is a timeout.
    assign to_exp = tmr_exp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (to_exp && ((state_q == RESUME && tgt_pause_ack[idx_q]) ||
                            (state_q == PAUSE  && !tgt_pause_ack[idx_q])))
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign to_exp = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        preq_d   = preq_q;
        pack_d   = pack_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_VAL;
        case (state_q)
            OFF: if (boot_en && !pause_req) begin
                state_d = REL_RST;
                idx_d   = '0;
            end
            REL_RST: begin
                rst_d[idx_q] = 1'b0;
                tmr_load     = 1'b1;
                state_d      = SETTLE;
            end
            SETTLE: if (tmr_exp) begin
                if (pause_req) begin
                    // This target never left pause: start pausing below it.
                    if (idx_q == '0) begin
                        state_d = PAUSED;
                        pack_d  = 1'b1;
                    end else begin
                        idx_d       = prv;
                        preq_d[prv] = 1'b1;
                        state_d     = PAUSE;
                    end
                end else begin
                    preq_d[idx_q] = 1'b0;
                    state_d       = RESUME;
                end
            end
            RESUME: if (!tgt_pause_ack[idx_q] || to_exp) begin
                if (pause_req) begin
                    // Current target is the highest released one.
                    preq_d[idx_q] = 1'b1;
                    state_d       = PAUSE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    pack_d  = 1'b0;
                end else begin
                    idx_d = nxt;
                    if (rst_q[nxt]) begin
                        state_d = REL_RST;
                    end else begin
                        preq_d[nxt] = 1'b0;
                        state_d     = RESUME;
                    end
                end
            end
            RUN: if (pause_req) begin
                idx_d            = LAST_IDX;
                preq_d[LAST_IDX] = 1'b1;
                state_d          = PAUSE;
            end
            PAUSE: if (tgt_pause_ack[idx_q] || to_exp) begin
                if (!pause_req) begin
                    preq_d[idx_q] = 1'b0;
                    state_d       = RESUME;
                end else if (idx_q == '0) begin
                    state_d = PAUSED;
                    pack_d  = 1'b1;
                end else begin
                    idx_d       = prv;
                    preq_d[prv] = 1'b1;
                end
            end
            PAUSED: if (!pause_req) begin
                idx_d     = '0;
                preq_d[0] = 1'b0;
                state_d   = RESUME;
            end
            default: state_d = OFF;
        endcase
`ifdef ADAM_SYSCFG_SEQ_TIMEOUT_EN
        // Fresh timeout on every entry into an ack wait, including index steps.
        if ((state_d == RESUME || state_d == PAUSE) && (state_d != state_q || idx_d != idx_q)) begin
            tmr_load = 1'b1;
            tmr_val  = TO_VAL;
        end
`endif
    end

    assign busy_d = (state_d != OFF) && (state_d != RUN) && (state_d != PAUSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            idx_q   <= '0;
            rst_q   <= '1;
            preq_q  <= '1;
            pack_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            preq_q  <= preq_d;
            pack_q  <= pack_d;
            busy_q  <= busy_d;
        end
    end

    adam_syscfg_seq_tmr #(.CNT_W(CNT_W)) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .value_i   (tmr_val),
        .expired_o (tmr_exp)
    );

    assign tgt_rst       = rst_q;
    assign tgt_pause_req = preq_q;
    assign pause_ack     = pack_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_adam_syscfg_seq.sv
// tb_adam_syscfg_seq
//   Self-checking bench for adam_syscfg_seq. Targets are modelled as pause acks
//   that follow their request after a per-target latency (1..6 cycles, random),
//   with an optional stuck-high ack. Expected event cycles come from the step
//   cost rule: each step is one cycle plus the ack latency, settle adds its count.
module tb_adam_syscfg_seq;

    localparam int NT = 4;
    localparam int S  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0, rst_n = 1'b0, boot_en = 1'b0, pause_req = 1'b0;
    logic          pause_ack, busy, err;
    logic [NT-1:0] tgt_rst, tgt_pause_req, tgt_pause_ack;

    int cyc = 0, n_cmp = 0, n_fail = 0;
    int lat [NT] = '{2, 2, 2, 2};
    logic [NT-1:0] stuck = '0;
    logic [NT-1:0] hist [8];

    adam_syscfg_seq #(.NO_TGTS(NT), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_en       (boot_en),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .tgt_rst       (tgt_rst),
        .tgt_pause_req (tgt_pause_req),
        .tgt_pause_ack (tgt_pause_ack),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: ack = request delayed by lat[i] cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= '1;
        end else begin
            hist[0] <= tgt_pause_req;
            for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        tgt_pause_ack = '0;
        for (int i = 0; i < NT; i++) tgt_pause_ack[i] = stuck[i] | hist[lat[i]-1][i];
    end

    task automatic set_lat(input bit rnd);
        for (int i = 0; i < NT; i++) lat[i] = rnd ? int'($urandom_range(1, 6)) : 2;
    endtask

    // Cycles from the boot_en sample edge to the RUN entry edge, plus one.
    function automatic int boot_len();
        int s = 1 + NT * (S + 2);
        for (int i = 0; i < NT; i++) s += lat[i];
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; boot_en = 1'b0; pause_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #23;
        n_cmp++; if (tgt_rst !== '1) begin n_fail++; $display("FAIL reset_rst got=%b exp=1111", tgt_rst); end
        n_cmp++; if (tgt_pause_req !== '1) begin n_fail++; $display("FAIL reset_preq got=%b exp=1111", tgt_pause_req); end
        n_cmp++; if ({pause_ack, busy, err} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got=%b exp=100", {pause_ack, busy, err}); end
        @(negedge clk); rst_n = 1'b1;
        // OFF must not start while upstream still requests pause.
        boot_en = 1'b1; pause_req = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if ({tgt_rst, busy} !== {4'b1111, 1'b0}) begin n_fail++; $display("FAIL off_hold got=%b/%b exp=1111/0", tgt_rst, busy); end
        boot_en = 1'b0; pause_req = 1'b0;
    endtask

    task automatic test_boot(input bit rnd);
        int c0, exp_e[NT], got_e[NT], exp_run, got_run, acc;
        logic [NT-1:0] prev;
        set_lat(rnd);
        do_reset();
        @(negedge clk); c0 = cyc; boot_en = 1'b1;
        acc = c0 + 2;
        for (int i = 0; i < NT; i++) begin exp_e[i] = acc; acc += S + 2 + lat[i]; got_e[i] = -1; end
        exp_run = c0 + boot_len();
        got_run = -1; prev = tgt_rst;
        for (int k = 0; k < 400 && got_run < 0; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL boot_busy got=%b exp=1", busy); end
            end
            for (int i = 0; i < NT; i++) if (prev[i] && !tgt_rst[i]) got_e[i] = cyc;
            if (pause_ack === 1'b0) got_run = cyc;
            prev = tgt_rst;
        end
        for (int i = 0; i < NT; i++) begin
            n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("FAIL boot_rst%0d cyc got=%0d exp=%0d", i, got_e[i], exp_e[i]); end
        end
        n_cmp++; if (got_run !== exp_run) begin n_fail++; $display("FAIL boot_run cyc got=%0d exp=%0d", got_run, exp_run); end
        n_cmp++; if ({tgt_rst, tgt_pause_req, busy} !== 9'b0) begin n_fail++; $display("FAIL boot_final got=%b/%b/%b exp=0/0/0", tgt_rst, tgt_pause_req, busy); end
    endtask

    task automatic test_pause();
        int c0, exp_e[NT], got_e[NT], exp_pa, got_pa;
        bit rst_bad = 0, order_bad = 0;
        logic [NT-1:0] prev;
        @(negedge clk); c0 = cyc; pause_req = 1'b1;
        exp_e[NT-1] = c0 + 1;
        for (int i = NT - 1; i > 0; i--) exp_e[i-1] = exp_e[i] + lat[i] + 1;
        exp_pa = exp_e[0] + lat[0] + 1;
        for (int i = 0; i < NT; i++) got_e[i] = -1;
        got_pa = -1; prev = tgt_pause_req;
        for (int k = 0; k < 200 && got_pa < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < NT; i++) if (!prev[i] && tgt_pause_req[i]) begin
                got_e[i] = cyc;
                if (i < NT - 1 && tgt_pause_ack[i+1] !== 1'b1) order_bad = 1;
            end
            if (tgt_rst !== '0) rst_bad = 1;
            if (pause_ack === 1'b1) got_pa = cyc;
            prev = tgt_pause_req;
        end
        for (int i = 0; i < NT; i++) begin
            n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("FAIL pause_req%0d cyc got=%0d exp=%0d", i, got_e[i], exp_e[i]); end
        end
        n_cmp++; if (got_pa !== exp_pa) begin n_fail++; $display("FAIL pause_ack cyc got=%0d exp=%0d", got_pa, exp_pa); end
        n_cmp++; if ({rst_bad, order_bad} !== 2'b00) begin n_fail++; $display("FAIL pause_rules rst_bad=%0d order_bad=%0d exp=0/0", rst_bad, order_bad); end
        n_cmp++; if ({tgt_pause_req, busy} !== {4'b1111, 1'b0}) begin n_fail++; $display("FAIL pause_final got=%b/%b exp=1111/0", tgt_pause_req, busy); end
    endtask

    task automatic test_resume();
        int c0, exp_e[NT], got_e[NT], exp_run, got_run;
        bit rst_bad = 0;
        logic [NT-1:0] prev;
        @(negedge clk); c0 = cyc; pause_req = 1'b0;
        exp_e[0] = c0 + 1;
        for (int i = 0; i < NT - 1; i++) exp_e[i+1] = exp_e[i] + lat[i] + 1;
        exp_run = exp_e[NT-1] + lat[NT-1] + 1;
        for (int i = 0; i < NT; i++) got_e[i] = -1;
        got_run = -1; prev = tgt_pause_req;
        for (int k = 0; k < 200 && got_run < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < NT; i++) if (prev[i] && !tgt_pause_req[i]) got_e[i] = cyc;
            if (tgt_rst !== '0) rst_bad = 1;
            if (pause_ack === 1'b0) got_run = cyc;
            prev = tgt_pause_req;
        end
        for (int i = 0; i < NT; i++) begin
            n_cmp++; if (got_e[i] !== exp_e[i]) begin n_fail++; $display("FAIL resume_req%0d cyc got=%0d exp=%0d", i, got_e[i], exp_e[i]); end
        end
        n_cmp++; if (got_run !== exp_run) begin n_fail++; $display("FAIL resume_run cyc got=%0d exp=%0d", got_run, exp_run); end
        n_cmp++; if (rst_bad !== 1'b0) begin n_fail++; $display("FAIL resume_rst_pulse got=%0d exp=0", rst_bad); end
    endtask

    task automatic test_pause_in_settle();
        int c0, e2, exp_e2, exp1, exp0, expd, got1, got0, gotd, k;
        bit pa_bad = 0;
        logic [NT-1:0] prev;
        set_lat(1);
        do_reset();
        @(negedge clk); c0 = cyc; boot_en = 1'b1;
        exp_e2 = c0 + 2 + (S + 2 + lat[0]) + (S + 2 + lat[1]);
        e2 = -1;
        for (k = 0; k < 200 && e2 < 0; k++) begin
            @(negedge clk);
            if (tgt_rst[2] === 1'b0) e2 = cyc;
        end
        pause_req = 1'b1;
        n_cmp++; if (e2 !== exp_e2) begin n_fail++; $display("FAIL settle_rst2 cyc got=%0d exp=%0d", e2, exp_e2); end
        exp1 = e2 + S; exp0 = exp1 + lat[1] + 1; expd = exp0 + lat[0] + 1;
        got1 = -1; got0 = -1; gotd = -1; prev = tgt_pause_req;
        for (k = 0; k < 200 && gotd < 0; k++) begin
            @(negedge clk);
            if (!prev[1] && tgt_pause_req[1]) got1 = cyc;
            if (!prev[0] && tgt_pause_req[0]) got0 = cyc;
            if (busy === 1'b0) gotd = cyc;
            if (pause_ack !== 1'b1) pa_bad = 1;
            prev = tgt_pause_req;
        end
        n_cmp++; if (got1 !== exp1) begin n_fail++; $display("FAIL settle_req1 cyc got=%0d exp=%0d", got1, exp1); end
        n_cmp++; if (got0 !== exp0) begin n_fail++; $display("FAIL settle_req0 cyc got=%0d exp=%0d", got0, exp0); end
        n_cmp++; if (gotd !== expd) begin n_fail++; $display("FAIL settle_paused cyc got=%0d exp=%0d", gotd, expd); end
        n_cmp++; if ({tgt_rst[3], tgt_pause_req, pa_bad} !== {1'b1, 4'b1111, 1'b0}) begin
            n_fail++; $display("FAIL settle_final rst3=%b preq=%b pa_bad=%0d exp=1/1111/0", tgt_rst[3], tgt_pause_req, pa_bad);
        end
        // Resume must settle target 3 for the first time and reach RUN.
        @(negedge clk); pause_req = 1'b0;
        for (k = 0; k < 300 && pause_ack !== 1'b0; k++) @(negedge clk);
        n_cmp++; if ({pause_ack, tgt_rst, tgt_pause_req} !== 9'b0) begin
            n_fail++; $display("FAIL settle_resume got=%b/%b/%b exp=0/0000/0000", pause_ack, tgt_rst, tgt_pause_req);
        end
    endtask

    task automatic test_reset_mid_pause();
        int c0, exp_run, got_run;
        boot_en = 1'b1;
        @(negedge clk); pause_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, tgt_pause_req[NT-1]} !== 2'b11) begin n_fail++; $display("FAIL midp_in_pause got=%b exp=11", {busy, tgt_pause_req[NT-1]}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({tgt_rst, tgt_pause_req, pause_ack, busy, err} !== {4'b1111, 4'b1111, 3'b100}) begin
            n_fail++; $display("FAIL midp_async got=%b/%b/%b%b%b exp=1111/1111/100", tgt_rst, tgt_pause_req, pause_ack, busy, err);
        end
        pause_req = 1'b0;
        @(negedge clk); rst_n = 1'b1; c0 = cyc;
        exp_run = c0 + boot_len();
        got_run = -1;
        for (int k = 0; k < 400 && got_run < 0; k++) begin
            @(negedge clk);
            if (k == 3) boot_en = 1'b0;  // late drop must be ignored
            if (pause_ack === 1'b0) got_run = cyc;
        end
        n_cmp++; if (got_run !== exp_run) begin n_fail++; $display("FAIL midp_reboot cyc got=%0d exp=%0d", got_run, exp_run); end
        n_cmp++; if (tgt_rst !== '0) begin n_fail++; $display("FAIL midp_rst got=%b exp=0000", tgt_rst); end
    endtask

    task automatic test_timeout();
        int e, k;
        set_lat(0);
        do_reset();
        stuck = 4'b0010;
        @(negedge clk); boot_en = 1'b1;
        e = -1;
        for (k = 0; k < 200 && e < 0; k++) begin
            @(negedge clk);
            if (tgt_pause_req[1] === 1'b0) e = cyc;
        end
        n_cmp++; if (e < 0) begin n_fail++; $display("FAIL to_resume1 got=none exp=req1 low"); end
`ifdef ADAM_SYSCFG_SEQ_TIMEOUT_EN
        while (cyc < e + TO - 1) @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_early got=%b exp=0", err); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_set got=%b exp=1", err); end
        for (k = 0; k < 300 && pause_ack !== 1'b0; k++) @(negedge clk);
        n_cmp++; if ({pause_ack, tgt_rst, err} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++; $display("FAIL to_run got=%b/%b/%b exp=0/0000/1", pause_ack, tgt_rst, err);
        end
`else
        repeat (60) @(negedge clk);
        n_cmp++; if ({busy, pause_ack, tgt_rst[2], tgt_pause_req[2], err} !== 5'b11110) begin
            n_fail++; $display("FAIL to_hold got=%b exp=11110", {busy, pause_ack, tgt_rst[2], tgt_pause_req[2], err});
        end
`endif
        stuck = '0;
        do_reset();
        @(negedge clk);
        n_cmp++; if ({err, busy, pause_ack} !== 3'b001) begin n_fail++; $display("FAIL to_cleared got=%b exp=001", {err, busy, pause_ack}); end
    endtask

    initial begin
        test_reset();
        test_boot(1'b0);
        for (int it = 0; it < 3; it++) begin
            repeat (10) @(negedge clk);
            if (it > 0) set_lat(1'b1);
            test_pause();
            test_resume();
        end
        test_boot(1'b1);
        test_pause_in_settle();
        test_reset_mid_pause();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
